// File: rtl/reg_file_master.sv
// Initiator for the 8-bit register-file port: sequences READ/WRITE/MOVE/CLEAR
// strobes from a valid/ready command stream and returns one response per command.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD    | rf_read high, rf_addr = rs, rf_data captured on exit
// WR    | rf_write high, rf_addr = rd, rf_in = imm (WRITE) or captured data (MOVE)
// CLR   | rf_write high, rf_addr = clr_cnt, rf_in = 0, one register per cycle
// RSP   | rsp_valid high, waits for rsp_ready
module reg_file_master #(
   parameter int DW = 8,
   parameter int AW = 8,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [RW-1:0] cmd_rs,
   input  logic [RW-1:0] cmd_rd,
   input  logic [DW-1:0] cmd_imm,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          busy,
   output logic          rf_write,
   output logic          rf_read,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_in,
   input  logic [DW-1:0] rf_data
);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_CLR,
      S_RSP
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q;
   logic [RW-1:0] rs_q, rd_q, clr_cnt;
   logic [DW-1:0] imm_q, data_q;
   logic [RW-1:0] idx;
   logic          clr_last;

   assign clr_last = (clr_cnt == {RW{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // data_q doubles as the response register and the MOVE holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_READ;
         rs_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         data_q  <= '0;
         clr_cnt <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (cmd_valid) begin
               op_q    <= cmd_op;
               rs_q    <= cmd_rs;
               rd_q    <= cmd_rd;
               imm_q   <= cmd_imm;
               clr_cnt <= '0;
            end
            S_RD:  data_q <= rf_data;
            S_WR:  if (op_q == OP_WRITE) data_q <= imm_q;
            S_CLR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_last) data_q <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            case (cmd_op)
               OP_WRITE: state_d = S_WR;
               OP_CLEAR: state_d = S_CLR;
               default:  state_d = S_RD;
            endcase
         end
         S_RD:    state_d = (op_q == OP_MOVE) ? S_WR : S_RSP;
         S_WR:    state_d = S_RSP;
         S_CLR:   if (clr_last) state_d = S_RSP;
         S_RSP:   if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rf_read  = 1'b0;
      rf_write = 1'b0;
      idx      = '0;
      rf_in    = '0;
      case (state_q)
         S_RD: begin
            rf_read = 1'b1;
            idx     = rs_q;
         end
         S_WR: begin
            rf_write = 1'b1;
            idx      = rd_q;
            rf_in    = (op_q == OP_WRITE) ? imm_q : data_q;
         end
         S_CLR: begin
            rf_write = 1'b1;
            idx      = clr_cnt;
         end
         default: ;
      endcase
   end

   assign rf_addr   = {{(AW-RW){1'b0}}, idx};
   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RSP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_data  = data_q;

endmodule

// File: tb/tb_reg_file_master.sv
// Bench for reg_file_master: behavioural register file, vector table with a
// response scoreboard, and hand sequences for back-pressure, CLEAR and reset.
module tb_reg_file_master;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01, MV = 2'b10, CL = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_rs = 4'h0;
   logic [3:0] cmd_rd = 4'h0;
   logic [7:0] cmd_imm = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       busy;
   logic       rf_write;
   logic       rf_read;
   logic [7:0] rf_addr;
   logic [7:0] rf_in;
   logic [7:0] rf_data;

   logic [7:0] mem [16];
   logic [7:0] sb [$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   reg_file_master #(.DW(8), .AW(8), .RW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs(cmd_rs), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .rf_write(rf_write), .rf_read(rf_read),
      .rf_addr(rf_addr), .rf_in(rf_in), .rf_data(rf_data)
   );

   assign rf_data = rf_read ? mem[rf_addr[3:0]] : 8'hzz;

   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   always @(posedge clk) if (rf_write) mem[rf_addr[3:0]] <= rf_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // response scoreboard and per-cycle strobe invariants
   always begin
      @(negedge clk);
      #1;
      chk("no_rd_and_wr", {31'd0, rf_read & rf_write}, 32'd0);
      chk("addr_hi_zero", {28'd0, rf_addr[7:4]}, 32'd0);
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else chk("rsp_data", {24'd0, rsp_data}, {24'd0, sb.pop_front()});
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] rs, input logic [3:0] rd,
                        input logic [7:0] imm, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rd = rd; cmd_imm = imm;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
      sb.push_back(exp);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp_done();
      int n = 0;
      while (rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("rsp_done_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] rs, input logic [3:0] rd,
                          input logic [7:0] imm, input logic [7:0] exp, input int lat);
      int n = 0;
      issue(op, rs, rd, imm, exp);
      @(negedge clk);
      if (op == WR) begin
         chk("wr_strobe", {31'd0, rf_write}, 32'd1);
         chk("wr_addr", {24'd0, rf_addr}, {28'd0, rd});
         chk("wr_in", {24'd0, rf_in}, {24'd0, imm});
      end else begin
         chk("rd_strobe", {31'd0, rf_read}, 32'd1);
         chk("rd_addr", {24'd0, rf_addr}, {28'd0, rs});
      end
      if (op == MV) begin
         @(negedge clk);
         n++;
         chk("mv_wr_strobe", {31'd0, rf_write}, 32'd1);
         chk("mv_wr_addr", {24'd0, rf_addr}, {28'd0, rd});
         chk("mv_wr_in", {24'd0, rf_in}, {24'd0, exp});
      end
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat);
      wait_rsp_done();
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] rs;
      logic [3:0] rd;
      logic [7:0] imm;
      logic [7:0] exp;
      int         lat;
   } vec_t;

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{WR, 4'd0, 4'd3,  8'hA5, 8'hA5, 1};
      vecs[1]  = '{RD, 4'd3, 4'd0,  8'h00, 8'hA5, 1};
      vecs[2]  = '{WR, 4'd0, 4'd5,  8'h3C, 8'h3C, 1};
      vecs[3]  = '{MV, 4'd5, 4'd9,  8'h00, 8'h3C, 2};
      vecs[4]  = '{RD, 4'd9, 4'd0,  8'h00, 8'h3C, 1};
      vecs[5]  = '{MV, 4'd9, 4'd9,  8'h00, 8'h3C, 2};
      vecs[6]  = '{RD, 4'd9, 4'd0,  8'h00, 8'h3C, 1};
      vecs[7]  = '{WR, 4'd0, 4'd0,  8'hC3, 8'hC3, 1};
      vecs[8]  = '{MV, 4'd0, 4'd15, 8'h00, 8'hC3, 2};
      vecs[9]  = '{RD, 4'd15, 4'd0, 8'h00, 8'hC3, 1};
      vecs[10] = '{RD, 4'd5, 4'd0,  8'h00, 8'h3C, 1};

      // reset values
      #12;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      chk("rst_strobes", {30'd0, rf_read, rf_write}, 32'd0);
      chk("rst_addr_in", {16'd0, rf_addr, rf_in}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_cmd(vecs[i].op, vecs[i].rs, vecs[i].rd, vecs[i].imm, vecs[i].exp, vecs[i].lat);

      // back-pressure: READ r3 held 10 cycles, next command waits for the handshake
      rsp_ready = 1'b0;
      issue(RD, 4'd3, 4'd0, 8'h00, 8'hA5);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = WR; cmd_rs = 4'd0; cmd_rd = 4'd2; cmd_imm = 8'h5A;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         chk("bp_rsp_stable", {24'd0, rsp_data}, 32'h0000_00A5);
         chk("bp_no_rf", {30'd0, rf_read, rf_write}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
      chk("bp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
      sb.push_back(8'h5A);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_wr", {31'd0, rf_write}, 32'd1);
      chk("bp_next_addr", {24'd0, rf_addr}, 32'd2);
      @(negedge clk);
      wait_rsp_done();

      // CLEAR: 16 consecutive writes of 0 at addr 0..15, response at E16
      for (int i = 0; i < 16; i++)
         run_cmd(WR, 4'd0, 4'(i), 8'h40 + 8'(i), 8'h40 + 8'(i), 1);
      issue(CL, 4'd0, 4'd0, 8'h00, 8'h00);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("clr_wr", {30'd0, rf_write, rsp_valid}, 32'd2);
         chk("clr_addr", {24'd0, rf_addr}, i);
         chk("clr_in", {24'd0, rf_in}, 32'd0);
      end
      @(negedge clk);
      chk("clr_latency", {31'd0, rsp_valid}, 32'd1);
      wait_rsp_done();
      for (int i = 0; i < 16; i++) run_cmd(RD, 4'(i), 4'd0, 8'h00, 8'h00, 1);

      // reset in the middle of CLEAR at clr_cnt=7
      for (int i = 0; i < 16; i++)
         run_cmd(WR, 4'd0, 4'(i), 8'h40 + 8'(i), 8'h40 + 8'(i), 1);
      issue(CL, 4'd0, 4'd0, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("mid_clr_addr", {24'd0, rf_addr}, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rf_write", {31'd0, rf_write}, 32'd0);
      chk("async_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
      chk("async_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
      chk("async_addr_in", {16'd0, rf_addr, rf_in}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++)
         run_cmd(RD, 4'(i), 4'd0, 8'h00, (i < 7) ? 8'h00 : 8'h40 + 8'(i), 1);

      @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
